// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcode/funct encodings, FSM states and decoded-instruction
// record shared by the multi-cycle MIPS-subset core.
`default_nettype none

package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_MEM, S_WB, S_DONE
    } state_t;

    typedef enum logic [3:0] {
        K_NOP, K_ADDU, K_SLT, K_JR, K_ADDIU, K_LW, K_SW, K_BEQ, K_BNE, K_JAL
    } kind_t;

    typedef struct packed {
        kind_t       kind;
        logic        illegal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
    } dec_t;

    // Anything not recognised becomes a flagged NOP.
    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d         = '0;
        d.rs      = ir[25:21];
        d.rt      = ir[20:16];
        d.rd      = ir[15:11];
        d.imm     = ir[15:0];
        d.target  = ir[25:0];
        d.kind    = K_NOP;
        d.illegal = 1'b1;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADDU: begin d.kind = K_ADDU; d.illegal = 1'b0; end
                    FN_SLT:  begin d.kind = K_SLT;  d.illegal = 1'b0; end
                    FN_JR:   begin d.kind = K_JR;   d.illegal = 1'b0; end
                    default: ;
                endcase
            end
            OP_ADDIU: begin d.kind = K_ADDIU; d.illegal = 1'b0; end
            OP_LW:    begin d.kind = K_LW;    d.illegal = 1'b0; end
            OP_SW:    begin d.kind = K_SW;    d.illegal = 1'b0; end
            OP_BEQ:   begin d.kind = K_BEQ;   d.illegal = 1'b0; end
            OP_BNE:   begin d.kind = K_BNE;   d.illegal = 1'b0; end
            OP_JAL:   begin d.kind = K_JAL;   d.illegal = 1'b0; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mc_alu.sv
// mips_mc_alu: combinational add / signed set-less-than / equality compare.
`default_nettype none

module mips_mc_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel_slt,
    output logic [DATA_W-1:0] y,
    output logic              eq
);

    logic lt;

    assign lt = $signed(a) < $signed(b);
    assign y  = sel_slt ? DATA_W'(lt) : a + b;
    assign eq = (a == b);

endmodule

`default_nettype wire

// File: rtl/mips_mc_core.sv
// mips_mc_core: parametrised 6-cycle-per-instruction MIPS-subset core with
// run-time loadable memories. Define MIPS_MC_PERF_EN to build the retired counter.
`default_nettype none

module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NREGS      = 32,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 32,
    parameter int PC_W       = 8,
    parameter int OUT_REG    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [PC_W-1:0]               start_pc,
    input  logic [PC_W-1:0]               prog_len,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    input  logic                          dmem_we,
    input  logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr,
    input  logic [DATA_W-1:0]             dmem_wdata,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             result,
    output logic                          illegal,
    output logic [15:0]                   retired
);

    localparam int RA_W  = $clog2(NREGS);
    localparam int IM_AW = $clog2(IMEM_DEPTH);
    localparam int DM_AW = $clog2(DMEM_DEPTH);

    state_t state, state_nx;

    logic [31:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    logic [DATA_W-1:0] regs [NREGS];

    logic [PC_W-1:0]   pc, plen, npc, npc_c, pc_inc, br_tgt;
    logic [31:0]       ir;
    dec_t              dec;
    logic [DATA_W-1:0] op_a, op_b, alu_q, mdr;
    logic [DATA_W-1:0] simm, alu_b, alu_y, rs_val, rt_val, wr_data;
    logic [RA_W-1:0]   rs_idx, rt_idx, wr_idx;
    logic [DM_AW-1:0]  maddr;
    logic              alu_eq, wr_kind, wr_en, accept, done_q, illegal_q;

    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign accept  = start && !busy;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign result  = regs[RA_W'(OUT_REG)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = (start_pc < prog_len) ? S_FETCH : S_DONE;
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = S_READ;
            S_READ:   state_nx = S_EXEC;
            S_EXEC:   state_nx = S_MEM;
            S_MEM:    state_nx = S_WB;
            S_WB:     state_nx = (npc < plen) ? S_FETCH : S_DONE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign rs_idx = RA_W'(dec.rs);
    assign rt_idx = RA_W'(dec.rt);
    assign rs_val = (32'(rs_idx) < NREGS) ? regs[rs_idx] : '0;
    assign rt_val = (32'(rt_idx) < NREGS) ? regs[rt_idx] : '0;

    assign simm  = DATA_W'(signed'(dec.imm));
    assign alu_b = (dec.kind == K_ADDIU || dec.kind == K_LW || dec.kind == K_SW) ? simm : op_b;

    mips_mc_alu #(.DATA_W(DATA_W)) u_alu (
        .a       (op_a),
        .b       (alu_b),
        .sel_slt (dec.kind == K_SLT),
        .y       (alu_y),
        .eq      (alu_eq)
    );

    // Branch targets are relative to the branch's own PC.
    assign pc_inc = pc + PC_W'(1);
    assign br_tgt = pc + PC_W'(signed'(dec.imm));

    always_comb begin
        npc_c = pc_inc;
        case (dec.kind)
            K_JR:    npc_c = PC_W'(op_a);
            K_BEQ:   npc_c = alu_eq ? br_tgt : pc_inc;
            K_BNE:   npc_c = alu_eq ? pc_inc : br_tgt;
            K_JAL:   npc_c = PC_W'(dec.target);
            default: ;
        endcase
    end

    generate
        if ((DMEM_DEPTH & (DMEM_DEPTH - 1)) == 0) begin : g_maddr_pow2
            assign maddr = DM_AW'(alu_q);
        end else begin : g_maddr_mod
            assign maddr = DM_AW'(alu_q % DATA_W'(DMEM_DEPTH));
        end
    endgenerate

    always_comb begin
        wr_idx  = RA_W'(dec.rd);
        wr_data = alu_q;
        wr_kind = 1'b0;
        case (dec.kind)
            K_ADDU, K_SLT: wr_kind = 1'b1;
            K_ADDIU: begin wr_idx = rt_idx; wr_kind = 1'b1; end
            K_LW:    begin wr_idx = rt_idx; wr_data = mdr; wr_kind = 1'b1; end
            K_JAL:   begin wr_idx = RA_W'(NREGS - 1); wr_kind = 1'b1; end
            default: ;
        endcase
    end

    assign wr_en = wr_kind && (wr_idx != '0) && (32'(wr_idx) < NREGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            plen      <= '0;
            npc       <= '0;
            ir        <= '0;
            dec       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            alu_q     <= '0;
            mdr       <= '0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            done_q <= (state_nx == S_DONE) && ((state != S_DONE) || accept);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc        <= start_pc;
                        plen      <= prog_len;
                        illegal_q <= 1'b0;
                    end
                end
                // Out-of-range fetches yield 0, which decodes as an illegal sll.
                S_FETCH:  ir <= (32'(pc) < IMEM_DEPTH) ? imem[IM_AW'(pc)] : '0;
                S_DECODE: dec <= decode(ir);
                S_READ: begin
                    op_a <= rs_val;
                    op_b <= rt_val;
                end
                S_EXEC: begin
                    alu_q <= (dec.kind == K_JAL) ? DATA_W'(pc_inc) : alu_y;
                    npc   <= npc_c;
                end
                S_MEM: if (dec.kind == K_LW) mdr <= dmem[maddr];
                S_WB: begin
                    pc <= npc;
                    if (dec.illegal) illegal_q <= 1'b1;
                    if (wr_en) regs[wr_idx] <= wr_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!busy && imem_we && (32'(imem_addr) < IMEM_DEPTH)) imem[imem_addr] <= imem_wdata;
        if (!busy && dmem_we && (32'(dmem_addr) < DMEM_DEPTH)) dmem[dmem_addr] <= dmem_wdata;
        else if (state == S_MEM && dec.kind == K_SW) dmem[maddr] <= op_b;
    end

`ifdef MIPS_MC_PERF_EN
    logic [15:0] ret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   ret_q <= '0;
        else if (accept)                           ret_q <= '0;
        else if (state == S_WB && ret_q != 16'hFFFF) ret_q <= ret_q + 16'd1;
    end

    assign retired = ret_q;
`else
    assign retired = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_core.sv
// tb_mips_mc_core: directed self-checking bench for mips_mc_core with a result scoreboard.
`default_nettype none

module tb_mips_mc_core;

`ifdef MIPS_MC_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_pc = '0;
    logic [7:0]  prog_len = '0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_addr = '0;
    logic [31:0] imem_wdata = '0;
    logic        dmem_we = 1'b0;
    logic [4:0]  dmem_addr = '0;
    logic [7:0]  dmem_wdata = '0;
    logic        busy, done, illegal;
    logic [7:0]  result;
    logic [15:0] retired;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    mips_mc_core dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .prog_len(prog_len),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .busy(busy), .done(done), .result(result), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ri(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] rr(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_i(input int a, input logic [31:0] w);
        @(negedge clk);
        imem_we = 1'b1; imem_addr = 4'(a); imem_wdata = w;
        @(negedge clk);
        imem_we = 1'b0;
    endtask

    task automatic load_d(input int a, input logic [7:0] w);
        @(negedge clk);
        dmem_we = 1'b1; dmem_addr = 5'(a); dmem_wdata = w;
        @(negedge clk);
        dmem_we = 1'b0;
    endtask

    // Pulse start, wait for done (bounded), then pop and compare the expected result.
    task automatic run(input string tag, input int spc, input int plen, input logic [7:0] exp_res,
                       input int limit, input bit poke, output int cyc);
        @(negedge clk);
        start = 1'b1; start_pc = 8'(spc); prog_len = 8'(plen);
        exp_q.push_back(exp_res);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < limit) begin
            if (poke && cyc == 3) begin
                imem_we = 1'b1; imem_addr = 4'd0; imem_wdata = 32'hDEADBEEF;
            end else begin
                imem_we = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        imem_we = 1'b0;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_result"}, {24'd0, result}, {24'd0, exp_q.pop_front()});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int nz;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        rst = 1'b0;

        // start_pc >= prog_len: straight to DONE
        run("empty", 5, 5, 8'h00, 10, 1'b0, cyc);
        check("empty_latency", cyc, 1);
        check("empty_retired", {16'd0, retired}, 32'd0);

        // sw/lw round trip, with an ignored imem write while busy
        load_i(0, ri(9, 0, 1, 'h5A));
        load_i(1, ri('h2B, 0, 1, 7));
        load_i(2, ri('h23, 0, 2, 7));
        run("swlw", 0, 3, 8'h5A, 100, 1'b1, cyc);
        check("swlw_latency", cyc, 19);
        check("swlw_dmem7", {24'd0, dut.dmem[7]}, 32'h5A);
        check("imem_busy_write", dut.imem[0], ri(9, 0, 1, 'h5A));
        check("swlw_retired", {16'd0, retired}, PERF ? 32'd3 : 32'd0);
        check("swlw_illegal", {31'd0, illegal}, 32'd0);

        // r0 protection
        load_i(0, ri(9, 0, 0, 9));
        load_i(1, rr(0, 0, 2, 'h21));
        run("r0", 0, 2, 8'h00, 100, 1'b0, cyc);
        check("r0_reg0", {24'd0, dut.regs[0]}, 32'd0);
        check("r0_retired", {16'd0, retired}, PERF ? 32'd2 : 32'd0);

        // Illegal opcode acts as NOP and is sticky until the next start
        load_i(0, {6'h3F, 26'd0});
        load_i(1, ri(9, 0, 2, 'h33));
        run("illop", 0, 2, 8'h33, 100, 1'b0, cyc);
        check("illop_flag", {31'd0, illegal}, 32'd1);
        check("illop_retired", {16'd0, retired}, PERF ? 32'd2 : 32'd0);
        run("illclr", 1, 2, 8'h33, 100, 1'b0, cyc);
        check("illclr_flag", {31'd0, illegal}, 32'd0);
        // Fetch beyond imem returns 0 (sll), flagged illegal
        run("farpc", 16, 17, 8'h33, 100, 1'b0, cyc);
        check("farpc_flag", {31'd0, illegal}, 32'd1);

        // Sum loop
        load_i(0,  ri(9, 0, 2, 0));
        load_i(1,  ri(9, 0, 3, 0));
        load_i(2,  rr(3, 1, 4, 'h2A));
        load_i(3,  ri(4, 0, 4, 8));
        load_i(4,  ri(9, 0, 5, 10));
        load_i(5,  ri(4, 5, 3, 6));
        load_i(6,  ri('h23, 3, 6, 0));
        load_i(7,  rr(2, 6, 2, 'h21));
        load_i(8,  ri(9, 3, 3, 1));
        load_i(9,  rr(3, 1, 4, 'h2A));
        load_i(10, ri(5, 0, 4, -5));
        load_i(11, rr(31, 0, 0, 'h08));
        load_i(12, ri('h23, 0, 1, 10));
        load_i(13, {6'h03, 26'd0});
        load_d(0, 8'hFF);
        load_d(1, 8'hFE);
        load_d(2, 8'hFD);
        load_d(10, 8'h03);
        run("sum", 12, 14, 8'hFA, 400, 1'b0, cyc);
        check("sum_latency", cyc, 26 * 6 + 1);
        check("sum_illegal", {31'd0, illegal}, 32'd0);
        check("sum_retired", {16'd0, retired}, PERF ? 32'd26 : 32'd0);

        // Reset during EXEC of the fifth instruction
        @(negedge clk);
        start = 1'b1; start_pc = 8'd12; prog_len = 8'd14;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 28) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.regs[i] !== 8'd0) nz++;
        check("mid_rst_regs", nz, 0);
        @(negedge clk);
        rst = 1'b0;
        run("rerun", 12, 14, 8'hFA, 400, 1'b0, cyc);
        check("rerun_illegal", {31'd0, illegal}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
